// File: rtl/arp_resolver.sv
`default_nettype none
// ============================================================================
// Module      : arp_resolver
// Description : ARP initiator. Resolves the peer MAC of a target IPv4 address.
//               It requests ARP request frames from the TX arbiter, matches
//               parsed ARP replies from the RX path and retries on timeout.
//               Once resolved, the MAC is held and optionally refreshed.
// Ports       :
//   aclk, areset         clock / synchronous active-high reset
//   resolve_start        pulse: resolve target_ip (accepted when not busy)
//   target_ip[31:0]      IPv4 address to resolve
//   arp_rq_start         level: ask TX arbiter for an ARP request frame
//   rq_ip_d_addr[31:0]   target IP for the request frame
//   arp_rq_done          pulse: request frame fully sent
//   rx_arp_*, rx_crc_ok  parsed ARP frame fields from RX (rx_arp_valid pulse)
//   rx_sender_ip/mac     ARP SPA / SHA fields
//   mac_d_addr[47:0]     resolved peer MAC, mac_valid when usable
//   busy                 resolution in progress
//   resolve_fail         pulse: all retries exhausted
// Revision    : 1.0 - initial release
// ============================================================================
module arp_resolver #(
    parameter int TIMEOUT_CYCLES = 125_000_000,
    parameter int MAX_RETRIES    = 3,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        resolve_start,
    input  logic [31:0] target_ip,
    output logic        arp_rq_start,
    output logic [31:0] rq_ip_d_addr,
    input  logic        arp_rq_done,
    input  logic        rx_arp_valid,
    input  logic        rx_arp_oper,
    input  logic        rx_crc_ok,
    input  logic [31:0] rx_sender_ip,
    input  logic [47:0] rx_sender_mac,
    output logic [47:0] mac_d_addr,
    output logic        mac_valid,
    output logic        busy,
    output logic        resolve_fail
);

    // One down-counter serves both the reply timeout and the refresh period.
    localparam int C_MAX_TIME = (TIMEOUT_CYCLES > REFRESH_CYCLES) ? TIMEOUT_CYCLES : REFRESH_CYCLES;
    localparam int TW         = $clog2(C_MAX_TIME + 1);

    localparam logic [TW-1:0] c_timeout_load = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] c_refresh_load = TW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
    localparam logic          c_refresh_en   = (REFRESH_CYCLES != 0);
    localparam logic [3:0]    c_max_retries  = 4'(MAX_RETRIES);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_send     = 3'd1;
    localparam logic [2:0] c_st_wait     = 3'd2;
    localparam logic [2:0] c_st_resolved = 3'd3;
    localparam logic [2:0] c_st_failed   = 3'd4;

    logic [2:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_retry_cnt;
    logic [31:0]   r_rq_ip;
    logic [47:0]   r_mac;
    logic          r_mac_valid;
    logic          r_fail;

    logic w_match;
    logic w_timer_zero;

    // A frame is relevant only if it is intact and comes from the target.
    assign w_match      = rx_arp_valid & rx_crc_ok & (rx_sender_ip == r_rq_ip);
    assign w_timer_zero = (r_timer == '0);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= c_st_idle;
            r_timer     <= '0;
            r_retry_cnt <= '0;
            r_rq_ip     <= '0;
            r_mac       <= '0;
            r_mac_valid <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_fail <= 1'b0;
            case (r_state)
                c_st_idle, c_st_failed: begin
                    if (resolve_start) begin
                        r_rq_ip     <= target_ip;
                        r_retry_cnt <= '0;
                        r_state     <= c_st_send;
                    end
                end
                c_st_send: begin
                    if (arp_rq_done) begin
                        r_timer <= c_timeout_load;
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    // A reply arriving on the timeout cycle still counts.
                    if (w_match && rx_arp_oper) begin
                        r_mac       <= rx_sender_mac;
                        r_mac_valid <= 1'b1;
                        r_timer     <= c_refresh_load;
                        r_state     <= c_st_resolved;
                    end else if (w_timer_zero) begin
                        if (r_retry_cnt < c_max_retries) begin
                            r_retry_cnt <= r_retry_cnt + 4'd1;
                            r_state     <= c_st_send;
                        end else begin
                            r_mac_valid <= 1'b0;
                            r_fail      <= 1'b1;
                            r_state     <= c_st_failed;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                c_st_resolved: begin
                    // Gratuitous updates from the peer (request or reply).
                    if (w_match) begin
                        r_mac <= rx_sender_mac;
                    end
                    if (resolve_start) begin
                        r_rq_ip     <= target_ip;
                        r_retry_cnt <= '0;
                        r_state     <= c_st_send;
                    end else if (c_refresh_en) begin
                        // mac_valid stays high while the refresh is in flight.
                        if (w_timer_zero) begin
                            r_retry_cnt <= '0;
                            r_state     <= c_st_send;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign arp_rq_start = (r_state == c_st_send);
    assign busy         = (r_state == c_st_send) || (r_state == c_st_wait);
    assign rq_ip_d_addr = r_rq_ip;
    assign mac_d_addr   = r_mac;
    assign mac_valid    = r_mac_valid;
    assign resolve_fail = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_arp_resolver.sv
`default_nettype none
// ============================================================================
// Module      : tb_arp_resolver
// Description : Scoreboard bench for arp_resolver. The stimulus process knows
//               the protocol timeline and pushes expected output events and
//               output snapshots; a negedge monitor detects output events and
//               compares them against the queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arp_resolver;

    localparam int T  = 100;
    localparam int MR = 2;
    localparam int RF = 500;

    localparam int K_RQ_RISE = 0;
    localparam int K_RQ_FALL = 1;
    localparam int K_MAC     = 2;
    localparam int K_MV_FALL = 3;
    localparam int K_FAIL    = 4;

    typedef struct {
        int          kind;
        int          cycle;
        logic [47:0] data;
    } ev_t;

    typedef struct {
        int          cycle;
        logic        rq;
        logic [31:0] ip;
        logic [47:0] mac;
        logic        mv;
        logic        busy;
        logic        fail;
    } snap_t;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        resolve_start = 1'b0;
    logic [31:0] target_ip = '0;
    logic        arp_rq_start;
    logic [31:0] rq_ip_d_addr;
    logic        arp_rq_done = 1'b0;
    logic        rx_arp_valid = 1'b0;
    logic        rx_arp_oper = 1'b0;
    logic        rx_crc_ok = 1'b0;
    logic [31:0] rx_sender_ip = '0;
    logic [47:0] rx_sender_mac = '0;
    logic [47:0] mac_d_addr;
    logic        mac_valid;
    logic        busy;
    logic        resolve_fail;

    arp_resolver #(
        .TIMEOUT_CYCLES (T),
        .MAX_RETRIES    (MR),
        .REFRESH_CYCLES (RF)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .resolve_start (resolve_start),
        .target_ip     (target_ip),
        .arp_rq_start  (arp_rq_start),
        .rq_ip_d_addr  (rq_ip_d_addr),
        .arp_rq_done   (arp_rq_done),
        .rx_arp_valid  (rx_arp_valid),
        .rx_arp_oper   (rx_arp_oper),
        .rx_crc_ok     (rx_crc_ok),
        .rx_sender_ip  (rx_sender_ip),
        .rx_sender_mac (rx_sender_mac),
        .mac_d_addr    (mac_d_addr),
        .mac_valid     (mac_valid),
        .busy          (busy),
        .resolve_fail  (resolve_fail)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    ev_t   evq[$];
    snap_t snq[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    finished = 1'b0;

    // Reference model of the observable resolver state.
    logic [31:0] m_ip    = '0;
    logic [47:0] m_mac   = '0;
    bit          m_valid = 1'b0;

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic goto_cycle(input int n);
        while (cyc < n) tick();
    endtask

    task automatic push_ev(input int kind, input int cycle, input logic [47:0] data);
        ev_t e;
        e.kind  = kind;
        e.cycle = cycle;
        e.data  = data;
        evq.push_back(e);
    endtask

    task automatic push_snap(input int cycle, input logic rq, input logic bz);
        snap_t s;
        s.cycle = cycle;
        s.rq    = rq;
        s.ip    = m_ip;
        s.mac   = m_mac;
        s.mv    = m_valid;
        s.busy  = bz;
        s.fail  = 1'b0;
        snq.push_back(s);
    endtask

    function automatic logic [47:0] rand_mac();
        logic [47:0] v;
        v = {16'($urandom), 32'($urandom)};
        if (v == m_mac) v = ~v;
        return v;
    endfunction

    task automatic drive_frame(input logic oper, input logic crc, input logic [31:0] ip,
                               input logic [47:0] mac);
        rx_arp_valid  = 1'b1;
        rx_arp_oper   = oper;
        rx_crc_ok     = crc;
        rx_sender_ip  = ip;
        rx_sender_mac = mac;
        tick();
        rx_arp_valid  = 1'b0;
        rx_arp_oper   = 1'($urandom);
        rx_crc_ok     = 1'($urandom);
    endtask

    // Issues resolve_start now; returns the cycle arp_rq_start should appear.
    task automatic start_resolve(input logic [31:0] ip, output int s);
        resolve_start = 1'b1;
        target_ip     = ip;
        m_ip          = ip;
        s             = cyc + 1;
        push_ev(K_RQ_RISE, s, {16'h0, ip});
        tick();
        resolve_start = 1'b0;
        target_ip     = $urandom;
    endtask

    // Serves the request/wait loop starting with arp_rq_start visible at s_in.
    // nto attempts time out; nto > MR ends in failure, otherwise the next
    // attempt gets a reply reply_off cycles after its done (-1 = random).
    task automatic do_attempts(input int s_in, input int done_dly, input int reply_off,
                               input int nto, input bit ign_start, input logic [47:0] mac);
        int s;
        int d;
        int r;
        s = s_in;
        for (int a = 0; a <= MR; a++) begin
            d = s + ((done_dly < 0) ? int'($urandom_range(0, 20)) : done_dly);
            goto_cycle(d);
            arp_rq_done = 1'b1;
            if (ign_start) begin
                resolve_start = 1'b1;
                target_ip     = m_ip ^ 32'h00FF_0000;
            end
            push_ev(K_RQ_FALL, d + 1, '0);
            tick();
            arp_rq_done   = 1'b0;
            resolve_start = 1'b0;
            // Frames that must all be ignored while waiting.
            drive_frame(1'b1, 1'b1, m_ip + 32'd1, rand_mac());
            drive_frame(1'b1, 1'b0, m_ip, rand_mac());
            drive_frame(1'b0, 1'b1, m_ip, rand_mac());
            push_snap(d + 4, 1'b0, 1'b1);
            if (a < nto) begin
                if (a < MR) begin
                    s = d + T + 1;
                    push_ev(K_RQ_RISE, s, {16'h0, m_ip});
                end else begin
                    if (m_valid) push_ev(K_MV_FALL, d + T + 1, '0);
                    push_ev(K_FAIL, d + T + 1, '0);
                    m_valid = 1'b0;
                    goto_cycle(d + T + 2);
                    return;
                end
            end else begin
                r = d + ((reply_off < 0) ? int'($urandom_range(4, T)) : reply_off);
                goto_cycle(r);
                push_ev(K_MAC, r + 1, mac);
                m_mac   = mac;
                m_valid = 1'b1;
                drive_frame(1'b1, 1'b1, m_ip, mac);
                return;
            end
        end
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin : stim
        int s;
        int v;
        int n;
        tick();
        tick();
        push_snap(cyc, 1'b0, 1'b0);
        tick();
        areset = 1'b0;
        tick();

        // Basic resolve with fixed timing.
        goto_cycle(cyc + 2);
        start_resolve(32'hC0A8_010A, s);
        do_attempts(s, 19, 30, 0, 1'b0, 48'h0011_2233_4455);
        push_snap(cyc + 1, 1'b0, 1'b0);
        goto_cycle(cyc + 2);

        // Peer update while resolved, plus a non-matching frame.
        n = cyc;
        push_ev(K_MAC, n + 1, 48'hAABB_CCDD_EEFF);
        m_mac = 48'hAABB_CCDD_EEFF;
        drive_frame(1'b0, 1'b1, m_ip, 48'hAABB_CCDD_EEFF);
        drive_frame(1'b1, 1'b1, m_ip ^ 32'h1, rand_mac());
        push_snap(cyc + 1, 1'b0, 1'b0);
        goto_cycle(cyc + 2);

        // New resolve with a start pulse during SEND that must be ignored.
        start_resolve(32'h0A00_0001, s);
        do_attempts(s, 3, -1, 1, 1'b1, rand_mac());
        goto_cycle(cyc + 2);

        // No reply at all: three requests then a single fail pulse.
        start_resolve(32'h0A00_0002, s);
        do_attempts(s, -1, -1, 3, 1'b0, rand_mac());
        n = cyc;
        drive_frame(1'b1, 1'b1, m_ip, rand_mac());
        push_snap(n + 1, 1'b0, 1'b0);
        goto_cycle(cyc + 2);

        // Reply exactly on the timeout cycle wins over the retry.
        start_resolve(32'hC0A8_010A, s);
        do_attempts(s, -1, T, 0, 1'b0, rand_mac());

        // Refresh that succeeds, then a refresh that exhausts its retries.
        v = cyc;
        push_snap(v + RF / 2, 1'b0, 1'b0);
        push_ev(K_RQ_RISE, v + RF, {16'h0, m_ip});
        do_attempts(v + RF, -1, -1, 1, 1'b0, rand_mac());
        v = cyc;
        push_ev(K_RQ_RISE, v + RF, {16'h0, m_ip});
        do_attempts(v + RF, -1, -1, 3, 1'b0, rand_mac());
        goto_cycle(cyc + 2);

        // Reset while a request is pending.
        start_resolve(32'h0A00_0003, s);
        goto_cycle(s + 1);
        areset = 1'b1;
        push_ev(K_RQ_FALL, s + 2, '0);
        if (m_valid) push_ev(K_MV_FALL, s + 2, '0);
        m_ip    = '0;
        m_mac   = '0;
        m_valid = 1'b0;
        push_snap(s + 2, 1'b0, 1'b0);
        tick();
        areset = 1'b0;
        goto_cycle(s + 3);
        arp_rq_done = 1'b1;
        tick();
        arp_rq_done = 1'b0;
        push_snap(s + 6, 1'b0, 1'b0);
        goto_cycle(s + 7);

        // Randomised resolutions.
        for (int i = 0; i < 10; i++) begin
            goto_cycle(cyc + int'($urandom_range(1, 5)));
            start_resolve($urandom, s);
            do_attempts(s, -1, ($urandom_range(0, 3) == 0) ? T : -1,
                        int'($urandom_range(0, 3)), 1'($urandom), rand_mac());
            if (m_valid && $urandom_range(0, 1) == 1) begin
                n = cyc;
                push_ev(K_MAC, n + 1, 48'h0);
                m_mac = rand_mac();
                evq[evq.size() - 1].data = m_mac;
                drive_frame(1'($urandom), 1'b1, m_ip, m_mac);
            end
        end

        goto_cycle(cyc + 5);
        finished = 1'b1;
    end

    // ---------------------------------------------------------------- monitor
    function automatic string kname(input int k);
        case (k)
            K_RQ_RISE: return "rq_rise";
            K_RQ_FALL: return "rq_fall";
            K_MAC:     return "mac";
            K_MV_FALL: return "mac_valid_fall";
            default:   return "resolve_fail";
        endcase
    endfunction

    logic        p_rq  = 1'b0;
    logic        p_mv  = 1'b0;
    logic [47:0] p_mac = '0;

    task automatic check_ev(input int kind, input logic [47:0] data);
        ev_t e;
        n_tests++;
        if (evq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s: got event at cycle %0d data=%h, required no event",
                     kname(kind), cyc, data);
        end else begin
            e = evq.pop_front();
            if (e.kind != kind || e.cycle != cyc || e.data !== data) begin
                n_fail++;
                $display("FAIL event_%s: got %s@%0d data=%h, required %s@%0d data=%h",
                         kname(e.kind), kname(kind), cyc, data, kname(e.kind), e.cycle, e.data);
            end
        end
    endtask

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    always @(negedge aclk) begin
        snap_t s;
        ev_t   e;
        if (arp_rq_start === 1'b1 && p_rq !== 1'b1)                check_ev(K_RQ_RISE, {16'h0, rq_ip_d_addr});
        if (arp_rq_start === 1'b0 && p_rq === 1'b1)                check_ev(K_RQ_FALL, '0);
        if (mac_valid === 1'b1 && (p_mv !== 1'b1 || mac_d_addr !== p_mac))
                                                                   check_ev(K_MAC, mac_d_addr);
        if (mac_valid === 1'b0 && p_mv === 1'b1)                   check_ev(K_MV_FALL, '0);
        if (resolve_fail === 1'b1)                                 check_ev(K_FAIL, '0);

        while (evq.size() > 0 && evq[0].cycle < cyc) begin
            e = evq.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_%s: got nothing by cycle %0d, required event at cycle %0d data=%h",
                     kname(e.kind), cyc, e.cycle, e.data);
        end

        while (snq.size() > 0 && snq[0].cycle <= cyc) begin
            s = snq.pop_front();
            n_tests++;
            if (s.cycle != cyc || arp_rq_start !== s.rq || rq_ip_d_addr !== s.ip ||
                mac_d_addr !== s.mac || mac_valid !== s.mv || busy !== s.busy ||
                resolve_fail !== s.fail) begin
                n_fail++;
                $display("FAIL snapshot@%0d: got rq=%b ip=%h mac=%h mv=%b busy=%b fail=%b at cycle %0d, required rq=%b ip=%h mac=%h mv=%b busy=%b fail=%b",
                         s.cycle, arp_rq_start, rq_ip_d_addr, mac_d_addr, mac_valid, busy,
                         resolve_fail, cyc, s.rq, s.ip, s.mac, s.mv, s.busy, s.fail);
            end
        end

        p_rq  = arp_rq_start;
        p_mv  = mac_valid;
        p_mac = mac_d_addr;

        if (finished) begin
            n_tests++;
            if (evq.size() != 0 || snq.size() != 0) begin
                n_fail++;
                $display("FAIL drain: got %0d events and %0d snapshots outstanding, required 0",
                         evq.size(), snq.size());
            end
            summary();
        end else if (cyc > 40000) begin
            n_tests++;
            n_fail++;
            $display("FAIL watchdog: got cycle %0d without completion, required finish by 40000", cyc);
            summary();
        end
    end

endmodule
`default_nettype wire

// File: doc/arp_resolver.md
Name: arp_resolver

Overview:
ARP initiator for the UDP/ARP stack. It resolves the peer MAC from a target IPv4 address. It asks the TX arbiter to send ARP requests, matches parsed ARP replies from the RX path, and retries on timeout. After resolution it holds the MAC and refreshes it periodically, so the UDP transmitter can address frames without a static MAC parameter.

Parameters:
TIMEOUT_CYCLES, 125_000_000, cycles to wait for a reply after each request completes (1 s at 125 MHz); must be ≥1.
MAX_RETRIES, 3, re-sends allowed after the first request before declaring failure; 0..15.
REFRESH_CYCLES, 0, cycles after resolution before an automatic re-resolve; 0 disables refresh.

Ports:
aclk  in  1  clock for all logic.
areset  in  1  synchronous reset, active-high.
resolve_start  in  1  one-cycle pulse: resolve target_ip.
target_ip  in  32  IPv4 to resolve; sampled only when resolve_start is accepted.
arp_rq_start  out  1  level: request an ARP request frame from the TX arbiter.
rq_ip_d_addr  out  32  target IP for the request frame; stable while arp_rq_start=1.
arp_rq_done  in  1  one-cycle pulse from TX: request frame fully sent.
rx_arp_valid  in  1  one-cycle pulse: parsed ARP frame fields valid.
rx_arp_oper  in  1  0=request, 1=reply.
rx_crc_ok  in  1  FCS of that frame good; qualified by rx_arp_valid.
rx_sender_ip  in  32  ARP SPA field.
rx_sender_mac  in  48  ARP SHA field.
mac_d_addr  out  48  resolved peer MAC.
mac_valid  out  1  mac_d_addr usable.
busy  out  1  resolution in progress (SEND or WAIT_REPLY).
resolve_fail  out  1  one-cycle pulse: retries exhausted.

Behaviour:
- Reset (sync, areset=1 at an aclk edge):
  - state=IDLE;
  - all outputs 0, including mac_d_addr=48'h0 and rq_ip_d_addr=0;
  - timer and retry_cnt cleared.
  - Reset mid-operation drops arp_rq_start on the next edge. No partial state survives.
- States: IDLE, SEND, WAIT_REPLY, RESOLVED, FAILED.
- Accepting a start:
  - resolve_start is accepted in IDLE, RESOLVED or FAILED.
  - On acceptance: latch target_ip→rq_ip_d_addr, retry_cnt=0, go to SEND. arp_rq_start=1 on the following cycle (1-cycle latency).
  - resolve_start is ignored in SEND and WAIT_REPLY.
- SEND:
  - arp_rq_start held at 1 until arp_rq_done=1.
  - Next cycle: arp_rq_start=0, state=WAIT_REPLY, timer=TIMEOUT_CYCLES-1.
  - The timer does not run in SEND.
  - arp_rq_done in any other state is ignored.
- Match condition: rx_arp_valid & rx_crc_ok & rx_sender_ip==rq_ip_d_addr.
- WAIT_REPLY:
  - Match with rx_arp_oper=1 → mac_d_addr=rx_sender_mac, mac_valid=1 on the next cycle, state=RESOLVED, refresh timer=REFRESH_CYCLES-1.
  - Otherwise the timer decrements each cycle.
  - Timer==0 with no match and retry_cnt<MAX_RETRIES → retry_cnt+1, go to SEND.
  - Timer==0 with no match and retry_cnt==MAX_RETRIES → FAILED, resolve_fail=1 for exactly one cycle, mac_valid=0, mac_d_addr retained.
  - Match and timeout in the same cycle: match wins.
  - Non-matching IP, oper=0, or crc_ok=0 → ignored.
- RESOLVED:
  - Any match (either oper) updates mac_d_addr on the next cycle; mac_valid stays 1.
  - If REFRESH_CYCLES≠0, the refresh timer decrements. At 0 → SEND with retry_cnt=0, mac_valid stays 1 throughout the refresh.
  - A refresh that exhausts retries → FAILED, mac_valid=0.
- IDLE / FAILED: RX frames are ignored.
- busy=1 exactly in SEND and WAIT_REPLY.
- Widths:
  - Timer is $clog2(max(TIMEOUT_CYCLES,REFRESH_CYCLES)+1) bits, down-counting, no wrap (leaves state at 0).
  - retry_cnt is 4 bits.
- Total requests per resolution = MAX_RETRIES+1.

Test Plan:
Sim params: TIMEOUT_CYCLES=100, MAX_RETRIES=2, REFRESH_CYCLES=0 unless noted.
1. Basic resolve:
   - Stimulus: resolve_start with target_ip=C0A8010A; arp_rq_done 20 cycles later; reply (oper=1, crc_ok=1, SPA=C0A8010A, SHA=001122334455) 30 cycles after that.
   - Required: arp_rq_start high 1 cycle after start, low 1 cycle after done; mac_valid=1 and mac_d_addr=001122334455 1 cycle after the reply; busy=0.
2. Timeout and retry:
   - Stimulus: no reply ever.
   - Required: exactly 3 arp_rq_start assertions, each WAIT_REPLY lasting 100 cycles; resolve_fail pulses once, 100 cycles after the 3rd arp_rq_done; mac_valid=0.
3. Filtering:
   - Stimulus, in WAIT_REPLY: reply with SPA=C0A8010B; reply with crc_ok=0; request with the matching SPA.
   - Required: all ignored, no state change. A good reply on the timeout cycle (timer=0) → RESOLVED, no retry.
4. Refresh (REFRESH_CYCLES=500):
   - Stimulus: after resolution, let the refresh timer expire.
   - Required: arp_rq_start reasserts 500 cycles after resolution with mac_valid held at 1. With no reply, mac_valid drops together with the resolve_fail pulse.
5. Update in RESOLVED and ignored start:
   - Stimulus: matching request with SHA=AABBCCDDEEFF; then resolve_start during SEND.
   - Required: mac_d_addr=AABBCCDDEEFF next cycle; the resolve_start during SEND is ignored (rq_ip_d_addr unchanged).
6. Reset mid-SEND:
   - Stimulus: areset for 1 cycle while arp_rq_start=1.
   - Required: all outputs 0 after the edge; a later arp_rq_done is ignored.
